// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encodings,
// default sizing and the one-hot grant constants.
package fifo_arb_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int DEPTH_DEF     = 8;
    localparam int CNT_W_DEF     = 4;
    localparam int MAX_BURST_DEF = 4;

    // State codes double as the one-hot grant, so grant is just the state.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_S0   = 2'b01;
    localparam logic [1:0] GRANT_S1   = 2'b10;

    function automatic arb_state_t grant_to_state(input logic [1:0] g);
        case (g)
            GRANT_S0: return G0;
            GRANT_S1: return G1;
            default:  return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fifo_arb_rr.sv
// Two-way round-robin picker. With both sources valid the source that
// was not served last wins; last_grant is the index of the last winner.
module fifo_arb_rr
    import fifo_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] next_grant
);

    // Pick the single valid source, or alternate when both request.
    always_comb begin
        next_grant = GRANT_NONE;
        case (valid)
            2'b01:   next_grant = GRANT_S0;
            2'b10:   next_grant = GRANT_S1;
            2'b11:   next_grant = last_grant ? GRANT_S0 : GRANT_S1;
            default: next_grant = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-port arbiter in front of the 8-entry synchronous FIFO.
// Round-robin between s0/s1 with bounded bursts, registered write strobe
// and data, and an occupancy check so the FIFO is never written while full.
// Optional build macro FIFO_ARB_STATS_EN adds per-source accept counters.
//
// state | meaning
// IDLE  | no grant; picks a source from the valids, no accept this cycle
// G0    | s0 owns the write port (grant = 01)
// G1    | s1 owns the write port (grant = 10)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s0_valid,
    input  logic [DATA_W-1:0] s0_data,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] s1_data,
    output logic              s1_ready,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_d_in,
    input  logic [CNT_W-1:0]  fifo_data_count,
    input  logic              fifo_wr_err,
    output logic [1:0]        grant,
    input  logic              err_clr,
    output logic              wr_err_sticky
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]       s0_count,
    output logic [15:0]       s1_count
`endif
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);

    arb_state_t         state;
    logic [BURST_W-1:0] burst_cnt;
    logic               last_grant;

    logic [CNT_W:0]     occupancy;
    logic               space_ok;
    logic               acc0;
    logic               acc1;
    logic               cur_valid;
    logic               oth_valid;
    logic               cur_acc;
    logic [BURST_W-1:0] burst_next;
    logic               burst_done;
    logic               rr_last;
    logic [1:0]         rr_grant;

    // A write registered last cycle is not yet in data_count, so count it here.
    assign occupancy = {1'b0, fifo_data_count} + {{CNT_W{1'b0}}, fifo_wr_en};
    assign space_ok  = occupancy < (CNT_W + 1)'(DEPTH);

    assign s0_ready = (state == G0) && space_ok;
    assign s1_ready = (state == G1) && space_ok;
    assign acc0     = s0_valid && s0_ready;
    assign acc1     = s1_valid && s1_ready;
    assign grant    = state;

    // Current/other source view of the inputs and burst bookkeeping.
    always_comb begin
        cur_valid  = (state == G1) ? s1_valid : s0_valid;
        oth_valid  = (state == G1) ? s0_valid : s1_valid;
        cur_acc    = acc0 || acc1;
        burst_next = burst_cnt + BURST_W'(cur_acc);
        burst_done = cur_acc && (burst_next == BURST_W'(MAX_BURST));
    end

    // While a grant is held the picker treats the holder as last served,
    // so at a switch point it hands the port to the other source.
    assign rr_last = (state == G0) ? 1'b0 :
                     (state == G1) ? 1'b1 : last_grant;

    fifo_arb_rr u_rr (
        .valid      ({s1_valid, s0_valid}),
        .last_grant (rr_last),
        .next_grant (rr_grant)
    );

    // Grant FSM; everything holds while the FIFO has no room.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state     <= grant_to_state(rr_grant);
                    burst_cnt <= '0;
                end
                G0, G1: begin
                    if (space_ok) begin
                        if (oth_valid && (!cur_valid || burst_done)) begin
                            state      <= grant_to_state(rr_grant);
                            burst_cnt  <= '0;
                            last_grant <= (state == G1);
                        end else if (!cur_valid && !oth_valid) begin
                            state     <= IDLE;
                            burst_cnt <= '0;
                        end else if (burst_done) begin
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_next;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    // Register the accepted word toward the FIFO; data holds when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_wr_en <= 1'b0;
            fifo_d_in  <= '0;
        end else if (acc0) begin
            fifo_wr_en <= 1'b1;
            fifo_d_in  <= s0_data;
        end else if (acc1) begin
            fifo_wr_en <= 1'b1;
            fifo_d_in  <= s1_data;
        end else begin
            fifo_wr_en <= 1'b0;
        end
    end

    // Sticky FIFO write-error flag; a new error beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_err_sticky <= 1'b0;
        end else if (fifo_wr_err) begin
            wr_err_sticky <= 1'b1;
        end else if (err_clr) begin
            wr_err_sticky <= 1'b0;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Per-source accepted-beat counters, free-running with wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_count <= '0;
            s1_count <= '0;
        end else begin
            if (acc0) s0_count <= s0_count + 16'd1;
            if (acc1) s1_count <= s1_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a vector table for per-cycle grant,
// ready, strobe and error-flag behaviour, plus sequences for bursts,
// round-robin alternation, back-to-back fill and mid-burst reset.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        s0_valid, s1_valid;
    logic [31:0] s0_data, s1_data;
    logic        s0_ready, s1_ready;
    logic        fifo_wr_en;
    logic [31:0] fifo_d_in;
    logic [3:0]  fifo_data_count;
    logic        fifo_wr_err;
    logic [1:0]  grant;
    logic        err_clr;
    logic        wr_err_sticky;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] s0_count, s1_count;
`endif

    logic        use_model;
    logic [3:0]  cnt_drv;
    logic [3:0]  model_cnt;
    logic        rd_en;
    int          env_err_cnt = 0;

    int          checks = 0;
    int          passed = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .s0_valid        (s0_valid),
        .s0_data         (s0_data),
        .s0_ready        (s0_ready),
        .s1_valid        (s1_valid),
        .s1_data         (s1_data),
        .s1_ready        (s1_ready),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_d_in       (fifo_d_in),
        .fifo_data_count (fifo_data_count),
        .fifo_wr_err     (fifo_wr_err),
        .grant           (grant),
        .err_clr         (err_clr),
        .wr_err_sticky   (wr_err_sticky)
`ifdef FIFO_ARB_STATS_EN
        ,
        .s0_count        (s0_count),
        .s1_count        (s1_count)
`endif
    );

    // Occupancy of the downstream FIFO: write lands at the edge the strobe is
    // high, reads drain one entry per cycle when enabled.
    assign fifo_data_count = use_model ? model_cnt : cnt_drv;

    always @(posedge clk) begin
        if (reset) begin
            model_cnt <= 4'd0;
        end else begin
            model_cnt <= model_cnt + {3'b0, fifo_wr_en} - {3'b0, (rd_en && model_cnt != 4'd0)};
            if (fifo_wr_en && model_cnt == 4'd8 && !rd_en) env_err_cnt <= env_err_cnt + 1;
        end
    end

    typedef struct {
        logic       rst, v0, v1, err, clr;
        logic [3:0] cnt;
        logic [1:0] g;
        logic       we, r0, r1, st;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic rst, v0, v1, err, clr, input logic [3:0] cnt,
                                input logic [1:0] g, input logic we, r0, r1, st);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.v1 = v1; v.err = err; v.clr = clr; v.cnt = cnt;
        v.g = g; v.we = we; v.r0 = r0; v.r1 = r1; v.st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One handshake cycle: note accepts before the edge, then verify the
    // registered strobe and data one cycle later against the scoreboard.
    task automatic step(output logic a0, output logic a1);
        logic [31:0] exp_word;
        @(negedge clk);
        a0 = s0_valid & s0_ready;
        a1 = s1_valid & s1_ready;
        if (a0) sb.push_back(s0_data);
        if (a1) sb.push_back(s1_data);
        @(posedge clk);
        #1;
        check("wr_latency", {31'b0, fifo_wr_en}, {31'b0, a0 | a1});
        if (fifo_wr_en) begin
            exp_word = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            check("wr_data", fifo_d_in, exp_word);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic a0, a1;
        int   n, n1, first, last, steps;
        logic got0;

        reset = 1'b1; s0_valid = 0; s1_valid = 0; s0_data = '0; s1_data = '0;
        fifo_wr_err = 0; err_clr = 0; use_model = 0; cnt_drv = 4'd0; rd_en = 0;

        //            rst v0 v1 err clr cnt   grant  we r0 r1 st
        tbl[0]  = mk(1, 0, 0, 0, 0, 4'd0, 2'b00, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 0, 4'd0, 2'b10, 0, 0, 1, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0, 4'd0, 2'b10, 1, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 4'd0, 2'b00, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 1, 0, 0, 4'd0, 2'b01, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 0, 4'd0, 2'b10, 0, 0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 4'd0, 2'b00, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 1, 0, 0, 4'd0, 2'b10, 0, 0, 1, 0);
        tbl[8]  = mk(0, 0, 0, 1, 0, 4'd0, 2'b00, 0, 0, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0, 4'd0, 2'b00, 0, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 1, 4'd0, 2'b00, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 1, 1, 4'd0, 2'b00, 0, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 1, 4'd0, 2'b00, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0, 1, 0, 4'd0, 2'b00, 0, 0, 0, 1);
        tbl[14] = mk(1, 0, 0, 0, 0, 4'd0, 2'b00, 0, 0, 0, 0);
        tbl[15] = mk(0, 1, 0, 0, 0, 4'd8, 2'b01, 0, 0, 0, 0);
        tbl[16] = mk(0, 1, 0, 0, 0, 4'd8, 2'b01, 0, 0, 0, 0);
        tbl[17] = mk(0, 1, 0, 0, 0, 4'd7, 2'b01, 1, 0, 0, 0);
        tbl[18] = mk(0, 1, 0, 0, 0, 4'd7, 2'b01, 0, 1, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 4'd0, 2'b00, 0, 0, 0, 0);

        s0_data = 32'h5A5A_0001;
        s1_data = 32'h6B6B_0002;
        for (int i = 0; i < 20; i++) begin
            reset = tbl[i].rst; s0_valid = tbl[i].v0; s1_valid = tbl[i].v1;
            fifo_wr_err = tbl[i].err; err_clr = tbl[i].clr; cnt_drv = tbl[i].cnt;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_grant", i),  {30'b0, grant},        {30'b0, tbl[i].g});
            check($sformatf("vec%0d_wr_en", i),  {31'b0, fifo_wr_en},   {31'b0, tbl[i].we});
            check($sformatf("vec%0d_s0_rdy", i), {31'b0, s0_ready},     {31'b0, tbl[i].r0});
            check($sformatf("vec%0d_s1_rdy", i), {31'b0, s1_ready},     {31'b0, tbl[i].r1});
            check($sformatf("vec%0d_sticky", i), {31'b0, wr_err_sticky}, {31'b0, tbl[i].st});
            if (i == 0 || i == 14) check($sformatf("vec%0d_d_in", i), fifo_d_in, 32'h0);
            if (i == 2) check("vec2_d_in_s1", fifo_d_in, 32'h6B6B_0002);
            if (i == 17) check("vec17_d_in_s0", fifo_d_in, 32'h5A5A_0001);
        end
        fifo_wr_err = 0; err_clr = 0; cnt_drv = 4'd0;

        // Back-to-back fill of an empty FIFO from s0 alone.
        use_model = 1; rd_en = 0;
        do_reset();
        s0_valid = 1; s0_data = 32'h0011_0011; n = 0; first = -1; last = -1;
        for (int c = 0; c < 30 && n < 8; c++) begin
            step(a0, a1);
            if (a0) begin
                if (n == 0) first = c;
                last = c;
                n++;
                s0_data = (n + 1) * 32'h0011_0011;
            end
        end
        check("a_accepts", n, 8);
        check("a_back_to_back", last - first, 7);
        check("a_ready_after8", {31'b0, s0_ready}, 32'd0);
        step(a0, a1);
        step(a0, a1);
        check("a_count_full", {28'b0, model_cnt}, 32'd8);
        check("a_ready_full", {31'b0, s0_ready}, 32'd0);
        check("a_no_overflow", env_err_cnt, 0);
        check("a_sticky_clear", {31'b0, wr_err_sticky}, 32'd0);
`ifdef FIFO_ARB_STATS_EN
        check("a_s0_count", {16'b0, s0_count}, 32'd8);
`endif

        // Both sources saturated with a draining FIFO: 4-beat alternation.
        rd_en = 1;
        do_reset();
        s0_valid = 1; s1_valid = 1; s0_data = 32'h0A00_0000; s1_data = 32'h0B00_0000;
        n = 0; steps = 0;
        for (int c = 0; c < 60 && n < 16; c++) begin
            step(a0, a1);
            steps++;
            if (a0 | a1) begin
                check($sformatf("b_src%0d", n), {31'b0, a1}, (n / 4) % 2);
                if (n == 0) check("b_first_word", fifo_d_in, 32'h0A00_0000);
                if (a0) s0_data = s0_data + 1;
                if (a1) s1_data = s1_data + 1;
                n++;
            end
        end
        check("b_accepts", n, 16);
        check("b_cycles", steps, 17);

        // s0 drops after 2 beats; s1 then gets a full burst before s0 returns.
        do_reset();
        s0_valid = 1; s1_valid = 1; s0_data = 32'hC000_0000; s1_data = 32'hC100_0000;
        n = 0;
        for (int c = 0; c < 10 && n < 2; c++) begin
            step(a0, a1);
            if (a0) begin n++; s0_data = s0_data + 1; end
        end
        check("c_s0_beats", n, 2);
        s0_valid = 0;
        step(a0, a1);
        check("c_grant_switch", {30'b0, grant}, 32'd2);
        n1 = 0; got0 = 0;
        for (int c = 0; c < 12 && !got0; c++) begin
            step(a0, a1);
            if (a1) begin
                n1++;
                s1_data = s1_data + 1;
                if (n1 == 1) s0_valid = 1;
            end
            if (a0) got0 = 1;
        end
        check("c_s1_burst", n1, 4);
        check("c_back_to_s0", {31'b0, got0}, 32'd1);

        // Reset in the middle of a G1 burst with a write pending.
        rd_en = 0;
        do_reset();
        s1_valid = 1; s1_data = 32'hD100_0001;
        step(a0, a1);
        fifo_wr_err = 1;
        step(a0, a1);
        fifo_wr_err = 0;
        check("d_wr_en_pending", {31'b0, fifo_wr_en}, 32'd1);
        check("d_sticky_set", {31'b0, wr_err_sticky}, 32'd1);
        s1_data = 32'hD100_0002;
        reset = 1;
        @(posedge clk);
        #1;
        check("d_wr_en", {31'b0, fifo_wr_en}, 32'd0);
        check("d_d_in", fifo_d_in, 32'h0);
        check("d_grant", {30'b0, grant}, 32'd0);
        check("d_sticky", {31'b0, wr_err_sticky}, 32'd0);
        check("d_s1_ready", {31'b0, s1_ready}, 32'd0);
        reset = 0;
        sb.delete();
        s0_valid = 1; s0_data = 32'hD000_0001;
        step(a0, a1);
        check("d_first_grant", {30'b0, grant}, 32'd1);
        step(a0, a1);
        check("d_first_accept_s0", {31'b0, a0}, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
